// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display link.
// Holds the hex glyph table (bit0 = segment a ... bit6 = segment g),
// the capture FSM state type and the default timing parameters.
package seven_seg_pkg;

  localparam int FREQ_DEF  = 20000;
  localparam int CBITS_DEF = 15;
  localparam int TOL_DEF   = 16;

  // Glyph for nibble value i lives at index i.
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2
  } state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Display-link monitor bus.
//   segment, sig : multiplexed pattern and its one-cycle strobe (from the link)
//   rx_word      : last complete frame {hi_pattern, lo_pattern}
//   hex_hi/lo    : decoded digits, hex_ok when both are legal glyphs
//   frame_valid  : one-cycle pulse when the frame outputs update
//   locked       : a good frame has arrived since reset or the last error
//   gap_err      : one-cycle pulse on a strobe-timing violation
// master = link/monitor side, slave = capture block.
interface seven_seg_capture_if;
  logic [6:0]  segment;
  logic        sig;
  logic [13:0] rx_word;
  logic [3:0]  hex_hi;
  logic [3:0]  hex_lo;
  logic        hex_ok;
  logic        frame_valid;
  logic        locked;
  logic        gap_err;

  modport master (
    output segment, sig,
    input  rx_word, hex_hi, hex_lo, hex_ok, frame_valid, locked, gap_err
  );

  modport slave (
    input  segment, sig,
    output rx_word, hex_hi, hex_lo, hex_ok, frame_valid, locked, gap_err
  );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
//   pattern : 7-bit segment pattern, bit0 = a
//   legal   : pattern is one of the 16 hex glyphs
//   nibble  : decoded value, 4'h0 when the pattern is not a glyph
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  // Glyphs are all distinct, so at most one table entry can match.
  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TBL[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the two-digit multiplexed seven-segment link.
// Samples `segment` on each `sig` strobe, pairs hi/lo digits into a
// 14-bit frame, decodes both digits and polices strobe spacing against
// the transmitter refresh period (FREQ+1 cycles, +/- TOL).
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : seven_seg_capture_if slave modport (inputs segment/sig, status outputs)
//
// state   | meaning
// IDLE    | unsynchronised; next strobe is taken as the hi digit, no gap check
// WAIT_LO | hi digit held, expecting the lo strobe inside the window
// WAIT_HI | frame done, expecting the next hi strobe inside the window
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int FREQ  = FREQ_DEF,
  parameter int CBITS = CBITS_DEF,
  parameter int TOL   = TOL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_capture_if.slave  bus
);

  localparam int GW     = CBITS + 1;
  localparam int LO_RAW = FREQ + 1 - TOL;
  localparam logic [GW-1:0] WIN_LO = (LO_RAW < 0) ? '0 : GW'(LO_RAW);
  localparam logic [GW-1:0] WIN_HI = GW'(FREQ + 1 + TOL);

  state_e          state_q, state_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [6:0]      hi_q, hi_d;
  logic [13:0]     rx_word_q, rx_word_d;
  logic [3:0]      hex_hi_q, hex_hi_d;
  logic [3:0]      hex_lo_q, hex_lo_d;
  logic            hex_ok_q, hex_ok_d;
  logic            frame_valid_q, frame_valid_d;
  logic            locked_q, locked_d;
  logic            gap_err_q, gap_err_d;

  logic            hi_legal, lo_legal;
  logic [3:0]      hi_nib, lo_nib;
  logic            in_window;

  // The hi digit decodes from the latch; the lo digit decodes straight off
  // the bus so the frame can complete on the lo strobe edge.
  seven_seg_decode u_dec_hi (
    .pattern (hi_q),
    .legal   (hi_legal),
    .nibble  (hi_nib)
  );

  seven_seg_decode u_dec_lo (
    .pattern (bus.segment),
    .legal   (lo_legal),
    .nibble  (lo_nib)
  );

  assign in_window = (gcnt_q >= WIN_LO) && (gcnt_q <= WIN_HI);

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    rx_word_d     = rx_word_q;
    hex_hi_d      = hex_hi_q;
    hex_lo_d      = hex_lo_q;
    hex_ok_d      = hex_ok_q;
    locked_d      = locked_q;
    frame_valid_d = 1'b0;
    gap_err_d     = 1'b0;

    // gcnt holds the spacing to the previous strobe at the moment a strobe
    // arrives; it saturates so a long silence cannot wrap back into window.
    if (bus.sig)
      gcnt_d = GW'(1);
    else if (&gcnt_q)
      gcnt_d = gcnt_q;
    else
      gcnt_d = gcnt_q + GW'(1);

    case (state_q)
      IDLE: begin
        if (bus.sig) begin
          hi_d    = bus.segment;
          state_d = WAIT_LO;
        end
      end

      WAIT_LO, WAIT_HI: begin
        // Early (or late) strobe and silence past the window both drop
        // sync; the errored strobe is discarded, not reused as a hi digit.
        if ((bus.sig && !in_window) || (!bus.sig && gcnt_q > WIN_HI)) begin
          gap_err_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = IDLE;
        end else if (bus.sig) begin
          if (state_q == WAIT_LO) begin
            rx_word_d     = {hi_q, bus.segment};
            hex_hi_d      = hi_nib;
            hex_lo_d      = lo_nib;
            hex_ok_d      = hi_legal && lo_legal;
            frame_valid_d = 1'b1;
            locked_d      = 1'b1;
            state_d       = WAIT_HI;
          end else begin
            hi_d    = bus.segment;
            state_d = WAIT_LO;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      gcnt_q        <= '0;
      hi_q          <= '0;
      rx_word_q     <= '0;
      hex_hi_q      <= '0;
      hex_lo_q      <= '0;
      hex_ok_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      gap_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gcnt_q        <= gcnt_d;
      hi_q          <= hi_d;
      rx_word_q     <= rx_word_d;
      hex_hi_q      <= hex_hi_d;
      hex_lo_q      <= hex_lo_d;
      hex_ok_q      <= hex_ok_d;
      frame_valid_q <= frame_valid_d;
      locked_q      <= locked_d;
      gap_err_q     <= gap_err_d;
    end
  end

  assign bus.rx_word     = rx_word_q;
  assign bus.hex_hi      = hex_hi_q;
  assign bus.hex_lo      = hex_lo_q;
  assign bus.hex_ok      = hex_ok_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = locked_q;
  assign bus.gap_err     = gap_err_q;

endmodule
